// File: rtl/ad9826_cfg_sequencer.sv
// Sequencer in front of the AD9826 serial-config engine: keeps a shadow of the
// eight config registers, sweeps them after reset/resync and serves host accesses.
module ad9826_cfg_sequencer #(
    parameter logic [71:0] INIT_VALUES = 72'h0,
    parameter int unsigned TIMEOUT     = 1024,
    parameter bit          VERIFY      = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        resync,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [2:0]  req_addr,
    input  logic [8:0]  req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [8:0]  rsp_data,
    output logic [15:0] cfg_word,
    output logic        cfg_toggle,
    input  logic        cfg_busy,
    input  logic        cfg_out_avail,
    input  logic [15:0] cfg_out_data,
    output logic        cfg_out_recieved,
    output logic        init_done,
    output logic        error,
    output logic [2:0]  err_addr
);

    localparam int unsigned NREG = 8;
    localparam int unsigned AW   = 3;
    localparam int unsigned DW   = 9;
    localparam int unsigned CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ISSUE,
        S_WAIT_BUSY_LO,
        S_WAIT_AVAIL,
        S_ACK,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            verify_ph_q, verify_ph_d;
    logic            sweep_q, sweep_d;
    logic            resync_pend_q, resync_pend_d;
    logic            lo_seen_q, lo_seen_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     word_q, word_d;
    logic            toggle_q, toggle_d;
    logic            recv_q, recv_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            init_done_q, init_done_d;
    logic            error_q, error_d;
    logic [AW-1:0]   err_addr_q, err_addr_d;
    logic [DW-1:0]   shadow_q [NREG];
    logic            shadow_we;
    logic            sweep_next;
    logic            abort;
    logic            timeout;

    logic            busy_m_q, busy_s_q;
    logic            avail_m_q, avail_s_q;
    logic [DW-1:0]   data_m_q, data_s_q;
    logic            unused_cfg_hi;

    assign unused_cfg_hi = ^cfg_out_data[15:9];

    // Engine runs on its own serial clock: two-flop synchronizers on its outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_m_q  <= 1'b0;
            busy_s_q  <= 1'b0;
            avail_m_q <= 1'b0;
            avail_s_q <= 1'b0;
            data_m_q  <= '0;
            data_s_q  <= '0;
        end else begin
            busy_m_q  <= cfg_busy;
            busy_s_q  <= busy_m_q;
            avail_m_q <= cfg_out_avail;
            avail_s_q <= avail_m_q;
            data_m_q  <= cfg_out_data[DW-1:0];
            data_s_q  <= data_m_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                shadow_q[i] <= INIT_VALUES[DW*i +: DW];
            end
        end else if (shadow_we) begin
            shadow_q[req_addr] <= req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_INIT;
            idx_q         <= '0;
            verify_ph_q   <= 1'b0;
            sweep_q       <= 1'b1;
            resync_pend_q <= 1'b0;
            lo_seen_q     <= 1'b0;
            cnt_q         <= '0;
            word_q        <= '0;
            toggle_q      <= 1'b0;
            recv_q        <= 1'b0;
            rdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            init_done_q   <= 1'b0;
            error_q       <= 1'b0;
            err_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            verify_ph_q   <= verify_ph_d;
            sweep_q       <= sweep_d;
            resync_pend_q <= resync_pend_d;
            lo_seen_q     <= lo_seen_d;
            cnt_q         <= cnt_d;
            word_q        <= word_d;
            toggle_q      <= toggle_d;
            recv_q        <= recv_d;
            rdata_q       <= rdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            init_done_q   <= init_done_d;
            error_q       <= error_d;
            err_addr_q    <= err_addr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        verify_ph_d   = verify_ph_q;
        sweep_d       = sweep_q;
        resync_pend_d = resync_pend_q | (resync && (state_q != S_IDLE));
        lo_seen_d     = lo_seen_q;
        cnt_d         = cnt_q;
        word_d        = word_q;
        toggle_d      = toggle_q;
        recv_d        = recv_q;
        rdata_d       = rdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        init_done_d   = init_done_q;
        error_d       = error_q;
        err_addr_d    = err_addr_q;
        shadow_we     = 1'b0;
        sweep_next    = 1'b0;
        abort         = 1'b0;
        timeout       = (cnt_q == CNT_LAST);

        case (state_q)
            S_IDLE: begin
                if (resync || resync_pend_q) begin
                    state_d       = S_INIT;
                    idx_d         = '0;
                    verify_ph_d   = 1'b0;
                    sweep_d       = 1'b1;
                    resync_pend_d = 1'b0;
                    init_done_d   = 1'b0;
                    error_d       = 1'b0;
                end else if (req_valid) begin
                    word_d    = {req_rw, req_addr, 3'b000, req_rw ? 9'h000 : req_data};
                    shadow_we = ~req_rw;
                    toggle_d  = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_INIT: begin
                word_d   = verify_ph_q ? {1'b1, idx_q, 3'b000, 9'h000}
                                       : {1'b0, idx_q, 3'b000, shadow_q[idx_q]};
                toggle_d = 1'b1;
                state_d  = S_ISSUE;
            end
            S_ISSUE: begin
                // Require busy low then high so a stale busy from an aborted op is not taken as an ack.
                if (timeout) begin
                    abort = 1'b1;
                end else if (busy_s_q && lo_seen_q) begin
                    toggle_d = 1'b0;
                    state_d  = word_q[15] ? S_WAIT_AVAIL : S_WAIT_BUSY_LO;
                end else if (!busy_s_q) begin
                    lo_seen_d = 1'b1;
                end
            end
            S_WAIT_BUSY_LO: begin
                if (timeout) begin
                    abort = 1'b1;
                end else if (!busy_s_q) begin
                    if (!sweep_q) begin
                        state_d = S_IDLE;
                    end else if (VERIFY) begin
                        verify_ph_d = 1'b1;
                        state_d     = S_INIT;
                    end else begin
                        sweep_next = 1'b1;
                    end
                end
            end
            S_WAIT_AVAIL: begin
                if (timeout) begin
                    abort = 1'b1;
                end else if (avail_s_q) begin
                    rdata_d = data_s_q;
                    recv_d  = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (timeout) begin
                    abort = 1'b1;
                end else if (!avail_s_q) begin
                    recv_d = 1'b0;
                    if (sweep_q) begin
                        if (rdata_q != shadow_q[idx_q]) begin
                            error_d    = 1'b1;
                            err_addr_d = idx_q;
                        end
                        sweep_next = 1'b1;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = rdata_q;
                        state_d     = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Engine never acknowledged: flag it and move on without the handshake.
        if (abort) begin
            toggle_d   = 1'b0;
            recv_d     = 1'b0;
            error_d    = 1'b1;
            err_addr_d = word_q[14:12];
            if (sweep_q) begin
                sweep_next = 1'b1;
            end else if (word_q[15]) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = 9'h1FF;
                state_d     = S_RESP;
            end else begin
                state_d = S_IDLE;
            end
        end

        if (sweep_next) begin
            verify_ph_d = 1'b0;
            if (idx_q == AW'(NREG - 1)) begin
                sweep_d     = 1'b0;
                init_done_d = 1'b1;
                state_d     = S_IDLE;
            end else begin
                idx_d   = idx_q + AW'(1);
                state_d = S_INIT;
            end
        end

        if (state_d != state_q) begin
            cnt_d = '0;
            if (state_d == S_ISSUE) begin
                lo_seen_d = 1'b0;
            end
        end else if (state_q inside {S_ISSUE, S_WAIT_BUSY_LO, S_WAIT_AVAIL, S_ACK}) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // resync wins over a simultaneous request, so ready is gated by it directly.
    assign req_ready        = (state_q == S_IDLE) && !resync && !resync_pend_q && !reset;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_data         = rsp_data_q;
    assign cfg_word         = word_q;
    assign cfg_toggle       = toggle_q;
    assign cfg_out_recieved = recv_q;
    assign init_done        = init_done_q;
    assign error            = error_q;
    assign err_addr         = err_addr_q;

endmodule
